// File: rtl/sobel_edge_conv_pkg.sv
// Shared widths, payload types and window helpers for the Sobel edge stage.
package sobel_edge_conv_pkg;

   localparam int unsigned SOBEL_LATENCY = 4;
   localparam int unsigned PIX_W         = 8;
   localparam int unsigned WIN_W         = 72;
   localparam int unsigned GRAD_W        = 11;
   localparam int unsigned SUM_W         = 10;
   localparam int unsigned ROW_BITS      = 3 * PIX_W;

   typedef logic [PIX_W-1:0]  pix_t;
   typedef logic [WIN_W-1:0]  win_t;
   typedef logic [SUM_W-1:0]  sum_t;
   typedef logic [GRAD_W-1:0] mag_t;

   // Column/row weighted sums produced by the first pipeline stage.
   typedef struct packed {
      sum_t xr;
      sum_t xl;
      sum_t yb;
      sum_t yt;
   } sums_t;

   // Signed horizontal/vertical gradients produced by the second stage.
   typedef struct packed {
      logic signed [GRAD_W-1:0] gx;
      logic signed [GRAD_W-1:0] gy;
   } grad_t;

   // Unpack p(r,c) from a window: r0 is the oldest line, c0 the leftmost column.
   function automatic pix_t pix(input win_t win, input int unsigned r, input int unsigned c);
      win_t shifted;
      shifted = win >> (ROW_BITS * r + PIX_W * (2 - c));
      return pix_t'(shifted);
   endfunction

   // 1-2-1 weighted sum; max 4*255 = 1020 fits in SUM_W bits.
   function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
      return sum_t'(a) + (sum_t'(b) << 1) + sum_t'(c);
   endfunction

   // Magnitude of a gradient; |-1020| still fits in GRAD_W bits.
   function automatic mag_t abs_grad(input logic signed [GRAD_W-1:0] g);
      return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
   endfunction

endpackage

// File: rtl/sobel_edge_conv_if.sv
// Window-in / edge-pixel-out bundle between the line-window stage, this block and its consumer.
interface sobel_edge_conv_if;
   import sobel_edge_conv_pkg::*;

   win_t i_pixel_data;
   logic i_pixel_data_valid;
   logic i_intr;
   pix_t o_pixel;
   logic o_pixel_valid;
   logic o_eol;
   logic o_eof;
   logic o_intr;

   modport master (
      output i_pixel_data,
      output i_pixel_data_valid,
      output i_intr,
      input  o_pixel,
      input  o_pixel_valid,
      input  o_eol,
      input  o_eof,
      input  o_intr
   );

   modport slave (
      input  i_pixel_data,
      input  i_pixel_data_valid,
      input  i_intr,
      output o_pixel,
      output o_pixel_valid,
      output o_eol,
      output o_eof,
      output o_intr
   );

endinterface

// File: rtl/sobel_grad_pipe.sv
// Three-stage gradient pipeline: weighted sums, signed gradients, |Gx|+|Gy|.
module sobel_grad_pipe
   import sobel_edge_conv_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  win_t win_i,
   input  logic valid_i,
   output mag_t mag_o,
   output logic valid_o
);

   localparam int unsigned PIPE_STAGES = SOBEL_LATENCY - 1;

   sums_t                  sums_d, sums_q;
   grad_t                  grad_d, grad_q;
   mag_t                   mag_d,  mag_q;
   logic [PIPE_STAGES-1:0] vld_d,  vld_q;

   // Stage 1: column sums for Gx and row sums for Gy.
   always_comb begin
      sums_d    = '0;
      sums_d.xr = wsum(pix(win_i, 0, 2), pix(win_i, 1, 2), pix(win_i, 2, 2));
      sums_d.xl = wsum(pix(win_i, 0, 0), pix(win_i, 1, 0), pix(win_i, 2, 0));
      sums_d.yb = wsum(pix(win_i, 2, 0), pix(win_i, 2, 1), pix(win_i, 2, 2));
      sums_d.yt = wsum(pix(win_i, 0, 0), pix(win_i, 0, 1), pix(win_i, 0, 2));
   end

   // Stage 2: signed differences; the 11-bit range never overflows.
   always_comb begin
      grad_d    = '0;
      grad_d.gx = $signed(GRAD_W'(sums_q.xr) - GRAD_W'(sums_q.xl));
      grad_d.gy = $signed(GRAD_W'(sums_q.yb) - GRAD_W'(sums_q.yt));
   end

   // Stage 3: L1 magnitude (0..2040) and valid shift.
   always_comb begin
      mag_d = abs_grad(grad_q.gx) + abs_grad(grad_q.gy);
      vld_d = {vld_q[PIPE_STAGES-2:0], valid_i};
   end

   // Pipeline registers; data advances every cycle, valid rides alongside.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sums_q <= '0;
         grad_q <= '0;
         mag_q  <= '0;
         vld_q  <= '0;
      end else begin
         sums_q <= sums_d;
         grad_q <= grad_d;
         mag_q  <= mag_d;
         vld_q  <= vld_d;
      end
   end

   assign mag_o   = mag_q;
   assign valid_o = vld_q[PIPE_STAGES-1];

endmodule

// File: rtl/sobel_edge_conv.sv
// Sobel edge stage: gradient pipe, output quantisation, line/frame tracking, interrupt re-timing.
module sobel_edge_conv
   import sobel_edge_conv_pkg::*;
#(
   parameter int unsigned IMG_WIDTH = 256,
   parameter int unsigned OUT_LINES = 254,
   parameter bit          THRESH_EN = 1'b1,
   parameter int unsigned THRESHOLD = 90
) (
   input logic               i_clk,
   input logic               i_rst_n,
   sobel_edge_conv_if.slave  pix_if
);

   localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned ROW_W = (OUT_LINES > 1) ? $clog2(OUT_LINES) : 1;

   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(OUT_LINES - 1);
   localparam mag_t             THRESH_MAG = mag_t'(THRESHOLD);
   localparam mag_t             SAT_LIMIT  = mag_t'(255);

   mag_t                     mag_s3;
   logic                     vld_s3;

   pix_t                     pix_d,  pix_q;
   logic                     vld_d,  vld_q;
   logic                     eol_d,  eol_q;
   logic                     eof_d,  eof_q;
   logic [COL_W-1:0]         col_d,  col_q;
   logic [ROW_W-1:0]         row_d,  row_q;
   logic [SOBEL_LATENCY-1:0] intr_d, intr_q;

   sobel_grad_pipe u_grad_pipe (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .win_i   (pix_if.i_pixel_data),
      .valid_i (pix_if.i_pixel_data_valid),
      .mag_o   (mag_s3),
      .valid_o (vld_s3)
   );

   // Stage 4: quantise magnitude; position counters advance with each emitted pixel.
   always_comb begin
      pix_d  = '0;
      vld_d  = vld_s3;
      eol_d  = 1'b0;
      eof_d  = 1'b0;
      col_d  = col_q;
      row_d  = row_q;
      intr_d = {intr_q[SOBEL_LATENCY-2:0], pix_if.i_intr};

      if (THRESH_EN) begin
         pix_d = (mag_s3 > THRESH_MAG) ? '1 : '0;
      end else begin
         pix_d = (mag_s3 > SAT_LIMIT) ? '1 : pix_t'(mag_s3);
      end

      if (vld_s3) begin
         if (col_q == COL_LAST) begin
            eol_d = 1'b1;
            col_d = '0;
            if (row_q == ROW_LAST) begin
               eof_d = 1'b1;
               row_d = '0;
            end else begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // Output, position and interrupt-delay registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pix_q  <= '0;
         vld_q  <= 1'b0;
         eol_q  <= 1'b0;
         eof_q  <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
         intr_q <= '0;
      end else begin
         pix_q  <= pix_d;
         vld_q  <= vld_d;
         eol_q  <= eol_d;
         eof_q  <= eof_d;
         col_q  <= col_d;
         row_q  <= row_d;
         intr_q <= intr_d;
      end
   end

   assign pix_if.o_pixel       = pix_q;
   assign pix_if.o_pixel_valid = vld_q;
   assign pix_if.o_eol         = eol_q;
   assign pix_if.o_eof         = eof_q;
   assign pix_if.o_intr        = intr_q[SOBEL_LATENCY-1];

endmodule

// File: tb/tb_sobel_edge_conv.sv
// Bench for sobel_edge_conv: two instances (binary threshold and saturating magnitude)
// driven by the same stream and checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_sobel_edge_conv;

   localparam int unsigned W     = 256;
   localparam int unsigned LINES = 2;
   localparam int unsigned TH    = 90;

   typedef struct packed { logic v; logic [71:0] w; logic i; } smp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld   = 1'b0;
   logic [71:0] win   = '0;
   logic        intr  = 1'b0;

   int n_checks  = 0;
   int n_fail    = 0;
   int out_idx   = 0;
   int first_eol = 0;
   int first_eof = 0;

   // model state
   smp_t        q[$];
   int          m_col = 0;
   int          m_row = 0;
   logic        exp_v, exp_eol, exp_eof, exp_intr, pix_chk;
   logic [7:0]  exp_pa, exp_pb;

   always #5 clk = ~clk;

   sobel_edge_conv_if bus_a ();
   sobel_edge_conv_if bus_b ();

   assign bus_a.i_pixel_data       = win;
   assign bus_a.i_pixel_data_valid = vld;
   assign bus_a.i_intr             = intr;
   assign bus_b.i_pixel_data       = win;
   assign bus_b.i_pixel_data_valid = vld;
   assign bus_b.i_intr             = intr;

   sobel_edge_conv #(.IMG_WIDTH(W), .OUT_LINES(LINES), .THRESH_EN(1'b1), .THRESHOLD(TH)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .pix_if(bus_a.slave));

   sobel_edge_conv #(.IMG_WIDTH(W), .OUT_LINES(LINES), .THRESH_EN(1'b0), .THRESHOLD(TH)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .pix_if(bus_b.slave));

   function automatic int px(input logic [71:0] w, input int r, input int c);
      logic [71:0] t;
      t = w >> (24 * r + 8 * (2 - c));
      return int'(t[7:0]);
   endfunction

   // Sobel L1 magnitude straight from the kernel definition.
   function automatic int ref_mag(input logic [71:0] w);
      int gx, gy;
      gx = (px(w,0,2) + 2*px(w,1,2) + px(w,2,2)) - (px(w,0,0) + 2*px(w,1,0) + px(w,2,0));
      gy = (px(w,2,0) + 2*px(w,2,1) + px(w,2,2)) - (px(w,0,0) + 2*px(w,0,1) + px(w,0,2));
      return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
   endfunction

   function automatic logic [7:0] ref_thr(input int m);
      return (m > int'(TH)) ? 8'hFF : 8'h00;
   endfunction

   function automatic logic [7:0] ref_sat(input int m);
      return (m > 255) ? 8'hFF : 8'(m);
   endfunction

   function automatic logic [71:0] rnd_win();
      logic [71:0] w;
      int mode;
      w    = '0;
      mode = int'($urandom_range(0, 3));
      for (int k = 0; k < 9; k++) begin
         logic [7:0] p;
         case (mode)
            0:       p = 8'($urandom);
            1:       p = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            2:       p = 8'($urandom_range(0, 24));
            default: p = 8'($urandom_range(100, 140));
         endcase
         w[8*k +: 8] = p;
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model + per-cycle compare. Inputs only change 1ns after a rising edge, so the
   // values seen at a falling edge are exactly what the next rising edge samples.
   initial begin
      logic rst_p;
      smp_t s_p, e;
      int   m;
      rst_p = 1'b0;
      s_p   = '0;
      forever begin
         @(negedge clk);
         if (!rst_p) begin
            q.delete();
            for (int k = 0; k < 3; k++) q.push_back('0);
            m_col = 0; m_row = 0;
            exp_v = 0; exp_eol = 0; exp_eof = 0; exp_intr = 0;
            exp_pa = 8'h00; exp_pb = 8'h00; pix_chk = 1'b1;
            out_idx = 0; first_eol = 0; first_eof = 0;
         end else begin
            q.push_back(s_p);
            e        = q.pop_front();
            exp_v    = e.v;
            exp_intr = e.i;
            exp_eol  = 1'b0;
            exp_eof  = 1'b0;
            pix_chk  = e.v;
            if (e.v) begin
               m       = ref_mag(e.w);
               exp_pa  = ref_thr(m);
               exp_pb  = ref_sat(m);
               exp_eol = (m_col == int'(W) - 1);
               exp_eof = exp_eol && (m_row == int'(LINES) - 1);
               if (exp_eol) begin
                  m_col = 0;
                  m_row = (m_row == int'(LINES) - 1) ? 0 : m_row + 1;
               end else begin
                  m_col++;
               end
            end
         end

         chk("valid_a", bus_a.o_pixel_valid, exp_v);
         chk("valid_b", bus_b.o_pixel_valid, exp_v);
         chk("eol_a",   bus_a.o_eol,         exp_eol);
         chk("eol_b",   bus_b.o_eol,         exp_eol);
         chk("eof_a",   bus_a.o_eof,         exp_eof);
         chk("eof_b",   bus_b.o_eof,         exp_eof);
         chk("intr_a",  bus_a.o_intr,        exp_intr);
         chk("intr_b",  bus_b.o_intr,        exp_intr);
         if (pix_chk) begin
            chk("pixel_a", bus_a.o_pixel, exp_pa);
            chk("pixel_b", bus_b.o_pixel, exp_pb);
         end

         if (bus_a.o_pixel_valid) begin
            out_idx++;
            if (bus_a.o_eol && first_eol == 0) first_eol = out_idx;
            if (bus_a.o_eof && first_eof == 0) first_eof = out_idx;
         end

         rst_p = rst_n;
         s_p.v = vld;
         s_p.w = win;
         s_p.i = intr;
      end
   end

   // One isolated window; literal expectations for both output modes.
   task automatic directed(input string nm, input logic [71:0] w, input int exp_m,
                           input logic [7:0] ea, input logic [7:0] eb);
      chk({nm, "_model_mag"}, ref_mag(w), exp_m);
      vld = 1'b1;
      win = w;
      tick();
      vld = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({nm, "_valid"}, bus_a.o_pixel_valid, 1'b1);
      chk({nm, "_thr"},   bus_a.o_pixel, ea);
      chk({nm, "_sat"},   bus_b.o_pixel, eb);
      tick();
      tick();
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_valid"}, {bus_a.o_pixel_valid, bus_b.o_pixel_valid}, 2'b00);
      chk({nm, "_pixel"}, {bus_a.o_pixel, bus_b.o_pixel}, 16'h0000);
      chk({nm, "_eol"},   {bus_a.o_eol, bus_b.o_eol}, 2'b00);
      chk({nm, "_eof"},   {bus_a.o_eof, bus_b.o_eof}, 2'b00);
      chk({nm, "_intr"},  {bus_a.o_intr, bus_b.o_intr}, 2'b00);
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;

      // reset state
      repeat (3) tick();
      @(negedge clk);
      check_all_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // directed windows
      directed("flat",     {9{8'h80}},                       0,    8'h00, 8'h00);
      directed("vertical", {3{8'h00, 8'hFF, 8'hFF}},         1020, 8'hFF, 8'hFF);
      directed("weak",     {3{8'h00, 8'h00, 8'h0F}},         60,   8'h00, 8'h3C);

      // interrupt re-timing: exactly 4 cycles later, one cycle wide
      intr = 1'b1;
      tick();
      intr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("intr_early", bus_a.o_intr, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("intr_at_4", bus_a.o_intr, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("intr_after", bus_a.o_intr, 1'b0);
      tick();

      // fresh frame with bubbles: eol on 256th output, eof on 512th
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      sent  = 0;
      while (sent < 600) begin
         vld  = ($urandom_range(0, 3) != 0);
         win  = rnd_win();
         intr = ($urandom_range(0, 15) == 0);
         if (vld) sent++;
         tick();
      end
      vld  = 1'b0;
      intr = 1'b0;
      repeat (6) tick();
      chk("first_eol_idx", first_eol, 256);
      chk("first_eof_idx", first_eof, 512);

      // reset in mid-line
      for (int k = 0; k < 100; k++) begin
         vld = 1'b1;
         win = rnd_win();
         tick();
      end
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      check_all_zero("midreset");
      tick();
      rst_n = 1'b1;
      vld   = 1'b1;
      win   = rnd_win();
      for (int k = 0; k < 3; k++) begin
         tick();
         win = rnd_win();
         @(negedge clk);
         chk("post_reset_quiet", bus_a.o_pixel_valid, 1'b0);
      end
      tick();
      win = rnd_win();
      @(negedge clk);
      chk("post_reset_first", bus_a.o_pixel_valid, 1'b1);
      tick();
      for (int k = 0; k < 300; k++) begin
         win = rnd_win();
         tick();
      end
      vld = 1'b0;
      repeat (6) tick();
      chk("restart_eol_idx", first_eol, 256);

      // long random run
      for (int k = 0; k < 10000; k++) begin
         vld  = ($urandom_range(0, 9) < 8);
         win  = rnd_win();
         intr = ($urandom_range(0, 9) == 0);
         tick();
      end
      vld  = 1'b0;
      intr = 1'b0;
      repeat (8) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
